// File: rtl/twiddle_gen.sv
// twiddle_gen: full-circle FFT twiddle generator, W = cos(2*pi*k/N) -/+ j*sin(2*pi*k/N), 2-stage valid/ready pipe
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_idx/in_inv request side;
//        out_valid/out_ready/tw_re/tw_im result side (signed Q1.(FFT_DW-1)); in_inv=1 gives +sin.
module twiddle_gen #(
  parameter int FFT_LENGTH = 1024,
  parameter int FFT_DW = 16,
  parameter int FFT_N = $clog2(FFT_LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FFT_N-1:0]  in_idx,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FFT_DW-1:0] tw_re,
  output logic [FFT_DW-1:0] tw_im
);
  localparam int QTR = FFT_LENGTH / 4;
  localparam int MAX = (1 << (FFT_DW - 1)) - 1;
  localparam real PI = 3.14159265358979323846;
  logic [FFT_DW-1:0] tbl [QTR+1];
  // Quarter-wave cosine table; cos >= 0 here, so +0.5 and truncate rounds half away from zero, 1.0 saturates to MAX.
  for (genvar m = 0; m <= QTR; m++) begin : g_tbl
    localparam real RAW = $cos(2.0 * PI * m / FFT_LENGTH) * (real'(MAX) + 1.0);
    localparam int RND = $rtoi(RAW + 0.5);
    assign tbl[m] = FFT_DW'(RND > MAX ? MAX : RND);
  end
  logic              s1_v_q, s1_v_d, s1_inv_q, s1_inv_d;
  logic [1:0]        s1_quad_q, s1_quad_d;
  logic [FFT_N-3:0]  s1_r_q, s1_r_d;
  logic              out_valid_q, out_valid_d;
  logic [FFT_DW-1:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;
  logic              advance;
  logic [FFT_N-2:0]  idx_a, idx_b;
  logic [FFT_DW-1:0] c_a, c_b, cs, sn, re, sin_s, im;
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign tw_re     = tw_re_q;
  assign tw_im     = tw_im_q;
  always_comb begin
    idx_a = {1'b0, s1_r_q};
    idx_b = (FFT_N-1)'(QTR) - idx_a;
    c_a = tbl[idx_a];
    c_b = tbl[idx_b];
    // Odd quadrants swap the two table ports; cos is negative in q1/q2, sin in q2/q3.
    cs = s1_quad_q[0] ? c_b : c_a;
    sn = s1_quad_q[0] ? c_a : c_b;
    re = (s1_quad_q[0] ^ s1_quad_q[1]) ? -cs : cs;
    sin_s = s1_quad_q[1] ? -sn : sn;
    im = s1_inv_q ? sin_s : -sin_s;
    s1_v_d = advance ? in_valid : s1_v_q;
    s1_inv_d = advance ? in_inv : s1_inv_q;
    s1_quad_d = advance ? in_idx[FFT_N-1:FFT_N-2] : s1_quad_q;
    s1_r_d = advance ? in_idx[FFT_N-3:0] : s1_r_q;
    out_valid_d = advance ? s1_v_q : out_valid_q;
    tw_re_d = advance ? re : tw_re_q;
    tw_im_d = advance ? im : tw_im_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_inv_q <= 1'b0;
      s1_quad_q <= '0;
      s1_r_q <= '0;
      out_valid_q <= 1'b0;
      tw_re_q <= '0;
      tw_im_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_inv_q <= s1_inv_d;
      s1_quad_q <= s1_quad_d;
      s1_r_q <= s1_r_d;
      out_valid_q <= out_valid_d;
      tw_re_q <= tw_re_d;
      tw_im_q <= tw_im_d;
    end
  end
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: scoreboard bench for twiddle_gen (N=1024/DW=16 main instance, N=8/DW=8 small instance)
module tb_twiddle_gen;
  localparam real PI = 3.14159265358979323846;
  typedef struct {int re; int im;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [9:0] in_idx;
  logic [15:0] tw_re, tw_im;
  logic in_valid8, in_ready8, out_valid8, out_ready8;
  logic [2:0] in_idx8;
  logic [7:0] re8, im8;
  exp_t sb[$], sb8[$];
  int total = 0, bad = 0;
  int drv_re, drv_im, drv8_re, drv8_im;
  bit rnd_done;
  int e8re[8] = '{127, 91, 0, -91, -127, -91, 0, 91};
  int e8im[8] = '{0, -91, -127, -91, 0, 91, 127, 91};

  twiddle_gen #(.FFT_LENGTH(1024), .FFT_DW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .tw_re(tw_re), .tw_im(tw_im));

  twiddle_gen #(.FFT_LENGTH(8), .FFT_DW(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_idx(in_idx8),
    .in_inv(1'b0), .out_valid(out_valid8), .out_ready(out_ready8), .tw_re(re8), .tw_im(im8));

  task automatic check(string tag, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  function automatic int fx(real x, int dw);
    real v;
    int m, r;
    m = (1 << (dw - 1)) - 1;
    v = x * (real'(m) + 1.0);
    r = v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return r > m ? m : (r < -m ? -m : r);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", int'(out_valid), 0);
        else begin
          e = sb.pop_front();
          check("re", int'($signed(tw_re)), e.re);
          check("im", int'($signed(tw_im)), e.im);
        end
      end
      if (in_valid && in_ready) sb.push_back('{drv_re, drv_im});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) sb8.delete();
    else begin
      if (out_valid8 && out_ready8) begin
        if (sb8.size() == 0) check("unexpected_out8", int'(out_valid8), 0);
        else begin
          e = sb8.pop_front();
          check("re8", int'($signed(re8)), e.re);
          check("im8", int'($signed(im8)), e.im);
        end
      end
      if (in_valid8 && in_ready8) sb8.push_back('{drv8_re, drv8_im});
    end
  end

  task automatic send(int k, bit inv, int er, int ei);
    in_idx = 10'(k);
    in_inv = inv;
    drv_re = er;
    drv_im = ei;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("send_timeout", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendk(int k, bit inv);
    real a;
    int s;
    a = 2.0 * PI * k / 1024.0;
    s = fx($sin(a), 16);
    send(k, inv, fx($cos(a), 16), inv ? s : -s);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int hr, hi;
    rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_inv = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_idx8 = '0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ov", int'(out_valid), 0);
    check("rst_re", int'(tw_re), 0);
    check("rst_im", int'(tw_im), 0);
    check("rst_rdy", int'(in_ready), 1);
    // quadrant corners back to back, then first-result latency
    send(0, 1'b0, 32767, 0);
    check("lat_first", int'(out_valid), 0);
    send(256, 1'b0, 0, -32767);
    check("lat_second", int'(out_valid), 1);
    send(512, 1'b0, -32767, 0);
    send(768, 1'b0, 0, 32767);
    send(128, 1'b0, 23170, -23170);
    send(128, 1'b1, 23170, 23170);
    send(384, 1'b0, -23170, -23170);
    send(1023, 1'b0, fx($cos(2.0 * PI * 1023 / 1024.0), 16), -fx($sin(2.0 * PI * 1023 / 1024.0), 16));
    drain();
    // stall for 3 cycles after the first result
    fork
      begin
        for (int k = 1; k <= 6; k++) sendk(k, 1'b0);
      end
      begin
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        check("stall_ov_seen", int'(out_valid), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        hr = int'(tw_re);
        hi = int'(tw_im);
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          check("stall_re", int'(tw_re), hr);
          check("stall_im", int'(tw_im), hi);
          check("stall_ov", int'(out_valid), 1);
          check("stall_rdy", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    // reset with two requests in flight
    sendk(10, 1'b0);
    sendk(20, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_ov", int'(out_valid), 0);
    check("mid_rst_re", int'(tw_re), 0);
    check("mid_rst_im", int'(tw_im), 0);
    check("mid_rst_rdy", int'(in_ready), 1);
    repeat (8) @(posedge clk);
    #1;
    sendk(5, 1'b0);
    check("post_rst_lat1", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("post_rst_lat2", int'(out_valid), 1);
    drain();
    // random sweep with random in_valid gaps and out_ready backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          sendk(int'($urandom_range(1023)), 1'($urandom_range(1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(3) != 0;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    // small instance, N=8 DW=8, full forward sweep
    for (int k = 0; k < 8; k++) begin
      in_idx8 = 3'(k);
      drv8_re = e8re[k];
      drv8_im = e8im[k];
      in_valid8 = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid8 = 1'b0;
    for (int n = 0; n < 50 && sb8.size() != 0; n++) @(negedge clk);
    check("drain8", sb8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
